// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive checker for the traffic-light led bus.
// Decodes the one-hot led pattern into a phase, measures each phase in clock
// cycles, checks phase order and per-phase min/max durations, and reports
// sticky error flags plus the measurement of every phase that ends.
module traffic_light_monitor #(
    parameter int          CNT_W    = 28,
    parameter int          RED_MIN  = 100000000,
    parameter int          RED_MAX  = 100000000,
    parameter int          AMB_MIN  = 8000001,
    parameter int          AMB_MAX  = 8000001,
    parameter int          GRN_MIN  = 55000001,
    parameter int          GRN_MAX  = 55000001,
    // Reset value of the completed-sequence counter (0 in normal use).
    parameter logic [15:0] SEQ_INIT = 16'd0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       led,
    input  logic             clr_err,
    output logic [1:0]       phase,
    output logic [1:0]       last_phase,
    output logic [CNT_W-1:0] last_dur,
    output logic             dur_valid,
    output logic [15:0]      seq_count,
    output logic             err_pattern,
    output logic             err_seq,
    output logic             err_timing,
    output logic             err_pulse
);

    typedef enum logic [1:0] {
        PH_UNSYNC = 2'd0,
        PH_RED    = 2'd1,
        PH_AMB    = 2'd2,
        PH_GRN    = 2'd3
    } phase_t;

    localparam logic [2:0] LED_RED = 3'b100;
    localparam logic [2:0] LED_AMB = 3'b010;
    localparam logic [2:0] LED_GRN = 3'b001;

    localparam logic [CNT_W-1:0] RED_MIN_C = CNT_W'(RED_MIN);
    localparam logic [CNT_W-1:0] RED_MAX_C = CNT_W'(RED_MAX);
    localparam logic [CNT_W-1:0] AMB_MIN_C = CNT_W'(AMB_MIN);
    localparam logic [CNT_W-1:0] AMB_MAX_C = CNT_W'(AMB_MAX);
    localparam logic [CNT_W-1:0] GRN_MIN_C = CNT_W'(GRN_MIN);
    localparam logic [CNT_W-1:0] GRN_MAX_C = CNT_W'(GRN_MAX);
    localparam logic [CNT_W-1:0] DUR_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DUR_SAT   = '1;

    phase_t           phase_q, phase_d;
    logic [2:0]       led_q, led_d;
    logic             first_q, first_d;
    logic [CNT_W-1:0] dur_q, dur_d;
    logic             stuck_q, stuck_d;
    logic [1:0]       last_phase_q, last_phase_d;
    logic [CNT_W-1:0] last_dur_q, last_dur_d;
    logic             dur_valid_q, dur_valid_d;
    logic [15:0]      seq_count_q, seq_count_d;
    logic             err_pattern_q, err_pattern_d;
    logic             err_seq_q, err_seq_d;
    logic             err_timing_q, err_timing_d;
    logic             err_pulse_q, err_pulse_d;

    logic             led_legal;
    logic             led_q_legal;
    logic             changed;
    logic [CNT_W-1:0] min_sel;
    logic [CNT_W-1:0] max_sel;
    logic [2:0]       led_expected;
    phase_t           phase_succ;
    logic             new_pat;
    logic             new_seq;
    logic             new_tim;

    assign led_legal   = (led == LED_RED) || (led == LED_AMB) || (led == LED_GRN);
    assign led_q_legal = (led_q == LED_RED) || (led_q == LED_AMB) || (led_q == LED_GRN);
    // The first sample after reset is treated as a change so that a bus that
    // is already red can be synced immediately.
    assign changed     = first_q || (led != led_q);

    // Duration limits and the only legal successor of the tracked phase.
    always_comb begin
        min_sel      = '0;
        max_sel      = DUR_SAT;
        led_expected = LED_RED;
        phase_succ   = PH_UNSYNC;
        case (phase_q)
            PH_RED: begin
                min_sel      = RED_MIN_C;
                max_sel      = RED_MAX_C;
                led_expected = LED_AMB;
                phase_succ   = PH_AMB;
            end
            PH_AMB: begin
                min_sel      = AMB_MIN_C;
                max_sel      = AMB_MAX_C;
                led_expected = LED_GRN;
                phase_succ   = PH_GRN;
            end
            PH_GRN: begin
                min_sel      = GRN_MIN_C;
                max_sel      = GRN_MAX_C;
                led_expected = LED_RED;
                phase_succ   = PH_RED;
            end
            default: begin
                min_sel      = '0;
                max_sel      = DUR_SAT;
                led_expected = LED_RED;
                phase_succ   = PH_RED;
            end
        endcase
    end

    // Next-state logic: phase tracking, duration measurement and error detection.
    always_comb begin
        phase_d       = phase_q;
        led_d         = led_q;
        first_d       = first_q;
        dur_d         = dur_q;
        stuck_d       = stuck_q;
        last_phase_d  = last_phase_q;
        last_dur_d    = last_dur_q;
        dur_valid_d   = 1'b0;
        seq_count_d   = seq_count_q;
        new_pat       = 1'b0;
        new_seq       = 1'b0;
        new_tim       = 1'b0;

        if (changed) begin
            first_d = 1'b0;
            led_d   = led;
            dur_d   = DUR_ONE;
            stuck_d = 1'b0;

            // Report the phase that just ended, if it was being tracked.
            if (phase_q != PH_UNSYNC) begin
                dur_valid_d  = 1'b1;
                last_phase_d = phase_q;
                last_dur_d   = dur_q;
                // A phase already flagged as stuck was reported once already.
                if ((dur_q < min_sel) && !stuck_q) begin
                    new_tim = 1'b1;
                end
            end

            if (!led_legal) begin
                // Only the entry into an illegal pattern is an error event.
                phase_d = PH_UNSYNC;
                if (first_q || led_q_legal) begin
                    new_pat = 1'b1;
                end
            end else if (phase_q == PH_UNSYNC) begin
                // Resync happens only on red; amber/green are ignored here.
                if (led == LED_RED) begin
                    phase_d = PH_RED;
                end
            end else if (led == led_expected) begin
                phase_d = phase_succ;
                // Reaching green tracked implies red and amber were followed.
                if (phase_q == PH_GRN) begin
                    seq_count_d = seq_count_q + 16'd1;
                end
            end else begin
                new_seq = 1'b1;
                phase_d = PH_UNSYNC;
            end
        end else begin
            if (dur_q != DUR_SAT) begin
                dur_d = dur_q + DUR_ONE;
            end
            // Stuck detection: fires on the cycle the count passes MAX.
            if ((phase_q != PH_UNSYNC) && !stuck_q && (dur_q == max_sel)) begin
                new_tim = 1'b1;
                stuck_d = 1'b1;
            end
        end
    end

    // Sticky flags: a new error wins over a simultaneous clear.
    always_comb begin
        err_pattern_d = new_pat ? 1'b1 : (clr_err ? 1'b0 : err_pattern_q);
        err_seq_d     = new_seq ? 1'b1 : (clr_err ? 1'b0 : err_seq_q);
        err_timing_d  = new_tim ? 1'b1 : (clr_err ? 1'b0 : err_timing_q);
        err_pulse_d   = new_pat || new_seq || new_tim;
    end

    // State and output registers; reset returns the monitor to UNSYNC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q       <= PH_UNSYNC;
            led_q         <= 3'b000;
            first_q       <= 1'b1;
            dur_q         <= '0;
            stuck_q       <= 1'b0;
            last_phase_q  <= 2'd0;
            last_dur_q    <= '0;
            dur_valid_q   <= 1'b0;
            seq_count_q   <= SEQ_INIT;
            err_pattern_q <= 1'b0;
            err_seq_q     <= 1'b0;
            err_timing_q  <= 1'b0;
            err_pulse_q   <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            led_q         <= led_d;
            first_q       <= first_d;
            dur_q         <= dur_d;
            stuck_q       <= stuck_d;
            last_phase_q  <= last_phase_d;
            last_dur_q    <= last_dur_d;
            dur_valid_q   <= dur_valid_d;
            seq_count_q   <= seq_count_d;
            err_pattern_q <= err_pattern_d;
            err_seq_q     <= err_seq_d;
            err_timing_q  <= err_timing_d;
            err_pulse_q   <= err_pulse_d;
        end
    end

    assign phase       = phase_q;
    assign last_phase  = last_phase_q;
    assign last_dur    = last_dur_q;
    assign dur_valid   = dur_valid_q;
    assign seq_count   = seq_count_q;
    assign err_pattern = err_pattern_q;
    assign err_seq     = err_seq_q;
    assign err_timing  = err_timing_q;
    assign err_pulse   = err_pulse_q;

endmodule
